bcd_sevenseg_scan: RTL and testbench
====================================

Name: bcd_sevenseg_scan

Overview:
- Reads packed BCD digits from the counter chain and drives a multiplexed, common-anode seven-segment display.
- Time-multiplexes DIGITS digits at a programmable refresh rate.
- Snapshots inputs once per frame so the display never tears.
- Decodes BCD to active-low segments, with optional leading-zero blanking and decimal points.

Parameters:
- DIGITS, 4, number of display digits (1..8); digit 0 is rightmost and least significant.
- REFRESH_DIV, 100000, clk cycles per digit slot (minimum 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- bcd_in  in  4*DIGITS  packed BCD; bits [4i+3:4i] are digit i
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit
- blank_lz  in  1  1 = suppress leading zeros
- an  out  DIGITS  anode enables, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset is synchronous, active-high on rst; clock is clk.
- Reset values:
  - prescaler = 0, index = 0
  - snapshot bcd/dp/blank_lz = 0
  - an = all 1s, seg = 7'h7F, dp = 1, frame = 0
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - tick = (prescaler == REFRESH_DIV-1).
- Index:
  - On tick, index advances by 1.
  - From DIGITS-1 it wraps to 0.
- Snapshot and frame:
  - On the tick that wraps index to 0, snapshot registers load bcd_in, dp_in and blank_lz.
  - On that same edge, frame is set to 1 for exactly one cycle.
  - Between frames, changes on the inputs have no effect on the display.
- Output register:
  - an, seg and dp are registered from (index, snapshot), with one-cycle latency.
  - an has exactly one bit low (bit = index) unless that digit is blanked, in which case an is all 1s.
- Decode (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Codes 10..15 are illegal and display a dash: 3F.
- Leading-zero blanking (when snapshot blank_lz = 1):
  - Digit i > 0 is blanked if digit i and every more-significant digit are 0 and have no dp request.
  - A dp request on a zero digit keeps it visible and ends blanking for all lower digits.
  - Digit 0 is never blanked.
- dp output = ~snapshot_dp[index] for visible digits; 1 for blanked digits.
- Reset mid-scan: all state returns to reset values on the next edge and the scan restarts at digit 0.
- After reset, the first frame displays the zeroed snapshot. The first frame pulse occurs DIGITS*REFRESH_DIV cycles after rst deasserts.

Optional Feature:
- Macro: SEG_DIM_EN
- When defined:
  - Adds input bright [3:0].
  - bright is captured into the snapshot at frame.
  - Within each slot, the enabled anode is driven low only while prescaler*16 < (bright+1)*REFRESH_DIV; otherwise an = all 1s.
  - Result: duty = (bright+1)/16; bright = 15 gives full on.
- When undefined: no bright port, and anodes are on for the full slot.

Test Plan:
- Reset: DIGITS=4, REFRESH_DIV=4, rst high 3 cycles -> an=1111, seg=7F, dp=1, frame=0. After release, frame pulses exactly 16 cycles later.
- Scan order: bcd_in=16'h1234, blank_lz=0, dp_in=0, after one frame -> each held 4 cycles:
  - an=1110 with seg=19
  - an=1101 with seg=30
  - an=1011 with seg=24
  - an=0111 with seg=79
- Leading zeros:
  - bcd_in=16'h0050, blank_lz=1, dp_in=0 -> slots 3 and 2 have an=1111; slot 1 seg=12; slot 0 seg=40.
  - Same with dp_in=4'b0100 -> slot 2 shows seg=40 with dp=0; slot 3 is blank.
- Illegal code: bcd_in=16'h00A0 -> slot 1 seg=3F; other slots show 0.
- No tearing: change bcd_in from 1234 to 5678 during slot 2 -> display stays 1234 until the next frame pulse, then shows 5678.
- Mid-scan reset: assert rst during slot 2 for 1 cycle -> next cycle an=1111, seg=7F; scan restarts at digit 0 with snapshot 0.

Source files
------------

// File: rtl/bcd_sevenseg_scan.sv
// Multiplexed common-anode seven-segment driver for packed BCD with per-frame input snapshot.
// Optional brightness dimming (per-slot PWM of the anode) is enabled by defining SEG_DIM_EN.
module bcd_sevenseg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
`ifdef SEG_DIM_EN
    input  logic [3:0]            bright,
`endif
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         prescaler;
    logic [IW-1:0]         index;
    logic                  tick;
    logic                  last_slot;
    logic [4*DIGITS-1:0]   snap_bcd;
    logic [DIGITS-1:0]     snap_dp;
    logic                  snap_blz;
    logic [DIGITS-1:0]     blank;
    logic                  lead;
    logic [3:0]            cur_bcd;
    logic                  lit_phase;
    logic [DIGITS-1:0]     an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign tick      = (prescaler == PW'(REFRESH_DIV - 1));
    assign last_slot = (index == IW'(DIGITS - 1));

`ifdef SEG_DIM_EN
    localparam int DW = PW + 5;
    logic [3:0] snap_bright;

    // Anode lit for the first (bright+1)/16 of each slot.
    assign lit_phase = (DW'({prescaler, 4'b0000}) <
                        (DW'(snap_bright) + DW'(1)) * DW'(REFRESH_DIV));
`else
    assign lit_phase = 1'b1;
`endif

    // Scan from the most significant digit down; the first non-zero or dp-marked digit ends blanking.
    always_comb begin
        blank = '0;
        lead  = snap_blz;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            if (lead && (snap_bcd[4*(DIGITS-k) +: 4] == 4'd0) && !snap_dp[DIGITS-k])
                blank[DIGITS-k] = 1'b1;
            else
                lead = 1'b0;
        end
    end

    always_comb begin
        cur_bcd = snap_bcd[4*index +: 4];
        an_next = '1;
        if (!blank[index] && lit_phase)
            an_next[index] = 1'b0;
        seg_next = blank[index] ? 7'h7F : decode(cur_bcd);
        dp_next  = blank[index] | ~snap_dp[index];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            index     <= '0;
            snap_bcd  <= '0;
            snap_dp   <= '0;
            snap_blz  <= 1'b0;
`ifdef SEG_DIM_EN
            snap_bright <= '0;
`endif
            an        <= '1;
            seg       <= 7'h7F;
            dp        <= 1'b1;
            frame     <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (tick) begin
                prescaler <= '0;
                if (last_slot) begin
                    index    <= '0;
                    snap_bcd <= bcd_in;
                    snap_dp  <= dp_in;
                    snap_blz <= blank_lz;
`ifdef SEG_DIM_EN
                    snap_bright <= bright;
`endif
                    frame    <= 1'b1;
                end else begin
                    index <= index + IW'(1);
                end
            end else begin
                prescaler <= prescaler + PW'(1);
            end
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Scoreboard bench for bcd_sevenseg_scan (DIGITS=4, REFRESH_DIV=4, default build).
module tb_bcd_sevenseg_scan;

    localparam int D = 4;
    localparam int R = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         blank;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    bcd_sevenseg_scan #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a new display request and queue what each slot should show once it is captured.
    task automatic drive(input logic [15:0] b, input logic [3:0] d, input logic z);
        bcd_in   = b;
        dp_in    = d;
        blank_lz = z;
        for (int i = 0; i < D; i++) begin
            exp_t e;
            logic [3:0] dig;
            e.blank = z && (i > 0);
            for (int j = i; j < D; j++)
                if (b[4*j +: 4] != 4'd0 || d[j]) e.blank = 1'b0;
            dig   = b[4*i +: 4];
            e.an  = e.blank ? 4'hF : ~(4'b0001 << i);
            e.seg = tbl[dig];
            e.dp  = e.blank ? 1'b1 : ~d[i];
            q.push_back(e);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame && n < 64);
        check("frame_timeout", {31'd0, frame}, 32'd1);
    endtask

    // Called at the sample where frame is high; checks the 16 cycles of the frame that follows.
    task automatic check_frame(input bit do_chg, input logic [15:0] chg);
        for (int s = 0; s < D; s++) begin
            exp_t e;
            if (q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
                return;
            end
            e = q.pop_front();
            for (int c = 0; c < R; c++) begin
                step();
                if (do_chg && s == 2 && c == 1) drive(chg, 4'b0000, 1'b0);
                check($sformatf("an_s%0d", s), {28'd0, an}, {28'd0, e.an});
                check($sformatf("dp_s%0d", s), {31'd0, dp}, {31'd0, e.dp});
                if (!e.blank) check($sformatf("seg_s%0d", s), {25'd0, seg}, {25'd0, e.seg});
                check("frame_pulse", {31'd0, frame}, {31'd0, (s == D-1 && c == R-1)});
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bcd_in = '0; dp_in = '0; blank_lz = 1'b0;
        repeat (3) step();
        check("rst_an",    {28'd0, an},    32'hF);
        check("rst_seg",   {25'd0, seg},   32'h7F);
        check("rst_dp",    {31'd0, dp},    32'd1);
        check("rst_frame", {31'd0, frame}, 32'd0);

        drive(16'h1234, 4'b0000, 1'b0);
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame && n < 64);
        check("first_frame", n, 16);
        check_frame(1'b0, 16'h0);

        drive(16'h0050, 4'b0000, 1'b1);
        wait_frame();
        check_frame(1'b0, 16'h0);

        drive(16'h0050, 4'b0100, 1'b1);
        wait_frame();
        check_frame(1'b0, 16'h0);

        drive(16'h00A0, 4'b0000, 1'b0);
        wait_frame();
        check_frame(1'b0, 16'h0);

        drive(16'h0000, 4'b0000, 1'b1);
        wait_frame();
        check_frame(1'b0, 16'h0);

        drive(16'h9876, 4'b1010, 1'b1);
        wait_frame();
        check_frame(1'b0, 16'h0);

        // Tearing: 5678 arrives mid slot 2 and must only appear after the next frame pulse.
        drive(16'h1234, 4'b0000, 1'b0);
        wait_frame();
        check_frame(1'b1, 16'h5678);
        check_frame(1'b0, 16'h0);

        repeat (9) step();
        rst = 1'b1;
        step();
        check("mrst_an",    {28'd0, an},    32'hF);
        check("mrst_seg",   {25'd0, seg},   32'h7F);
        check("mrst_dp",    {31'd0, dp},    32'd1);
        check("mrst_frame", {31'd0, frame}, 32'd0);
        rst = 1'b0;
        step();
        check("mrst_an0",  {28'd0, an},  32'hE);
        check("mrst_seg0", {25'd0, seg}, 32'h40);
        check("mrst_dp0",  {31'd0, dp},  32'd1);
        n = 1;
        while (!frame && n < 64) begin
            step();
            n++;
        end
        check("mrst_frame_delay", n, 16);

        check("sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
